// File: rtl/demultiplexor_1in_3out_pkg.sv
// Shared constants for the 1-to-3 registered demultiplexor.
//   DEFAULT_WIDTH : default data width of the input word and all channels
//   SEL_A/B/C     : destination select codes for channels A, B, C
//   SEL_INV       : illegal select code (word discarded, error flagged)
//   ERRCNT_W      : width of the saturating illegal-select counter
package demultiplexor_1in_3out_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned ERRCNT_W      = 8;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_C   = 2'd2;
  localparam logic [1:0] SEL_INV = 2'd3;

endpackage : demultiplexor_1in_3out_pkg

// File: rtl/demultiplexor_1in_3out_demux_slot.sv
// One-entry output register with a valid/ready handshake.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   load       : capture data this edge (sets valid)
//   data       : word to capture
//   ready      : consumer takes the held word this edge
//   valid      : slot holds a word not yet taken
//   out        : held word (kept after drain; only a load changes it)
module demux_slot #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] out
);

  // A load on the same edge as a drain wins, so full throughput has no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      out   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      out   <= data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule : demux_slot

// File: rtl/demultiplexor_1in_3out.sv
// Registered 1-to-3 data distributor: routes Dato to channel A, B or C by Sel;
// Sel = 3 discards the word and pulses sel_err for one cycle.
// Optional feature macro: DEMUX_ERRCNT_EN adds the 8-bit saturating err_count port.
// Ports:
//   clk, reset           : clock and asynchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready is combinational from Sel)
//   Dato, Sel            : input word and destination select
//   SalidaA/B/C, validA/B/C, readyA/B/C : per-channel data and handshake
//   sel_err              : registered one-cycle pulse after an illegal-select accept
//   err_count            : illegal-select count (DEMUX_ERRCNT_EN only)
module demultiplexor_1in_3out
  import demultiplexor_1in_3out_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Dato,
  input  logic [1:0]       Sel,
  output logic [WIDTH-1:0] SalidaA,
  output logic [WIDTH-1:0] SalidaB,
  output logic [WIDTH-1:0] SalidaC,
  output logic             validA,
  output logic             validB,
  output logic             validC,
  input  logic             readyA,
  input  logic             readyB,
  input  logic             readyC,
  output logic             sel_err
`ifdef DEMUX_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  logic accept;
  logic load_a;
  logic load_b;
  logic load_c;
  logic err_hit;

  // Only the currently selected channel can stall the producer.
  always_comb begin
    in_ready = 1'b1;
    case (Sel)
      SEL_A:   in_ready = !validA || readyA;
      SEL_B:   in_ready = !validB || readyB;
      SEL_C:   in_ready = !validC || readyC;
      default: in_ready = 1'b1;
    endcase
  end

  // Select decode of an accepted word.
  always_comb begin
    accept  = in_valid && in_ready;
    load_a  = accept && (Sel == SEL_A);
    load_b  = accept && (Sel == SEL_B);
    load_c  = accept && (Sel == SEL_C);
    err_hit = accept && (Sel == SEL_INV);
  end

  demux_slot #(.W(WIDTH)) u_slot_a (
    .clk   (clk),
    .reset (reset),
    .load  (load_a),
    .data  (Dato),
    .ready (readyA),
    .valid (validA),
    .out   (SalidaA)
  );

  demux_slot #(.W(WIDTH)) u_slot_b (
    .clk   (clk),
    .reset (reset),
    .load  (load_b),
    .data  (Dato),
    .ready (readyB),
    .valid (validB),
    .out   (SalidaB)
  );

  demux_slot #(.W(WIDTH)) u_slot_c (
    .clk   (clk),
    .reset (reset),
    .load  (load_c),
    .data  (Dato),
    .ready (readyC),
    .valid (validC),
    .out   (SalidaC)
  );

  // Illegal-select flag, one cycle per accepted illegal word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= err_hit;
    end
  end

`ifdef DEMUX_ERRCNT_EN
  // Saturating illegal-select counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_hit && (err_count != '1)) begin
      err_count <= err_count + ERRCNT_W'(1);
    end
  end
`endif

endmodule : demultiplexor_1in_3out
